// File: rtl/turn_seq_pkg.sv
// Shared types and helpers for the round-robin turn sequencer.
// Helpers work on a fixed 8-player vector; callers zero-extend narrower vectors.
package turn_seq_pkg;

  localparam int MAX_PLAYERS = 8;
  localparam int MAX_PID_W   = 3;

  typedef enum logic [2:0] {
    START_SCREEN = 3'd0,
    TURN         = 3'd1,
    ADVANCE      = 3'd2,
    GAME_OVER    = 3'd3
  } state_t;

  function automatic logic [3:0] popcount(input logic [MAX_PLAYERS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  // Returns 0 for an all-zero vector.
  function automatic logic [MAX_PID_W-1:0] lowest_set_index(input logic [MAX_PLAYERS-1:0] v);
    logic [MAX_PID_W-1:0] idx;
    idx = 3'd0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      idx = v[i] ? MAX_PID_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/turn_sequencer_rr.sv
// Rotate-priority search: first alive index after cur_i, wrapping modulo
// N_PLAYERS, with cur_i itself as the final candidate.
module rr_next_alive #(
  parameter  int N_PLAYERS = 2,
  localparam int PID_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic [N_PLAYERS-1:0] alive_i,
  input  logic [PID_W-1:0]     cur_i,
  output logic [PID_W-1:0]     next_o,
  output logic                 found_o
);

  logic [PID_W-1:0] cand_s;

  // Walk candidates from farthest to nearest so the nearest alive one wins.
  always_comb begin
    next_o  = cur_i;
    found_o = 1'b0;
    cand_s  = cur_i;
    for (int k = N_PLAYERS; k >= 1; k--) begin
      cand_s  = PID_W'((int'(cur_i) + k) % N_PLAYERS);
      next_o  = alive_i[cand_s] ? cand_s : next_o;
      found_o = found_o | alive_i[cand_s];
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Round-robin turn sequencer for 2..8 players: skips dead players, enforces an
// optional per-turn timeout and reports a winner or a draw.
module turn_sequencer
  import turn_seq_pkg::*;
#(
  parameter  int N_PLAYERS    = 2,
  parameter  int HP_W         = 10,
  parameter  int TURN_TIMEOUT = 0,
  localparam int PID_W        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PLAYERS-1:0]        enter_pressed,
  input  logic [N_PLAYERS-1:0]        turn_done,
  input  logic [N_PLAYERS*HP_W-1:0]   hp_flat,
  output logic [N_PLAYERS-1:0]        turn_onehot,
  output logic [PID_W-1:0]            active_player,
  output logic [2:0]                  state_out,
  output logic                        start_game,
  output logic                        next_turn,
  output logic                        start_remote,
  output logic                        timeout_pulse,
  output logic [PID_W-1:0]            winner,
  output logic                        winner_valid,
  output logic                        draw
);

  localparam int TMR_W = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;
  localparam logic TMO_EN = (TURN_TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMO_EN ? TMR_W'(TURN_TIMEOUT - 1) : {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
  localparam logic [N_PLAYERS-1:0] ONEHOT_BASE = N_PLAYERS'(1'b1);

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [PID_W-1:0]       active_q, active_d;
  logic [N_PLAYERS-1:0]   onehot_q, onehot_d;
  logic                   start_game_q, start_game_d;
  logic                   next_turn_q, next_turn_d;
  logic                   start_remote_q, start_remote_d;
  logic                   timeout_q, timeout_d;
  logic [PID_W-1:0]       winner_q, winner_d;
  logic                   winner_valid_q, winner_valid_d;
  logic                   draw_q, draw_d;

  logic [N_PLAYERS-1:0]   alive_s;
  logic [MAX_PLAYERS-1:0] alive_ext_s;
  logic [MAX_PLAYERS-1:0] enter_ext_s;
  logic [3:0]             alive_cnt_s;
  logic                   game_end_s;
  logic                   done_act_s;
  logic                   alive_act_s;
  logic                   tmo_hit_s;
  logic [PID_W-1:0]       starter_s;
  logic [PID_W-1:0]       go_winner_s;
  logic [PID_W-1:0]       rr_next_s;
  logic                   rr_found_s;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_alive
    assign alive_s[i] = |hp_flat[i*HP_W +: HP_W];
  end

  assign alive_ext_s = MAX_PLAYERS'(alive_s);
  assign enter_ext_s = MAX_PLAYERS'(enter_pressed);
  assign alive_cnt_s = popcount(alive_ext_s);
  assign game_end_s  = (alive_cnt_s <= 4'd1);
  assign done_act_s  = turn_done[active_q];
  assign alive_act_s = alive_s[active_q];
  assign tmo_hit_s   = TMO_EN && (timer_q == TMO_LAST);
  assign starter_s   = PID_W'(lowest_set_index(enter_ext_s));
  assign go_winner_s = PID_W'(lowest_set_index(alive_ext_s));

  rr_next_alive #(.N_PLAYERS(N_PLAYERS)) u_rr (
    .alive_i (alive_s),
    .cur_i   (active_q),
    .next_o  (rr_next_s),
    .found_o (rr_found_s)
  );

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    active_d       = active_q;
    start_game_d   = start_game_q;
    start_remote_d = 1'b0;
    timeout_d      = 1'b0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    draw_d         = draw_q;
    next_turn_d    = 1'b0;
    onehot_d       = {N_PLAYERS{1'b0}};
    case (state_q)
      START_SCREEN: begin
        if (|enter_pressed) begin
          state_d        = TURN;
          active_d       = starter_s;
          timer_d        = {TMR_W{1'b0}};
          start_game_d   = 1'b1;
          start_remote_d = |starter_s;
        end else begin
          state_d = START_SCREEN;
        end
      end
      TURN: begin
        if (game_end_s) begin
          state_d        = GAME_OVER;
          winner_d       = go_winner_s;
          winner_valid_d = (alive_cnt_s == 4'd1);
          draw_d         = (alive_cnt_s == 4'd0);
        end else if (done_act_s || !alive_act_s) begin
          state_d = ADVANCE;
        end else if (tmo_hit_s) begin
          state_d   = ADVANCE;
          timeout_d = 1'b1;
        end else begin
          // Saturate so a disabled timeout never lets the counter wrap.
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1'b1);
        end
      end
      ADVANCE: begin
        if (game_end_s) begin
          state_d        = GAME_OVER;
          winner_d       = go_winner_s;
          winner_valid_d = (alive_cnt_s == 4'd1);
          draw_d         = (alive_cnt_s == 4'd0);
        end else begin
          state_d  = TURN;
          active_d = rr_found_s ? rr_next_s : active_q;
          timer_d  = {TMR_W{1'b0}};
        end
      end
      GAME_OVER: begin
        if (|enter_pressed) begin
          state_d        = START_SCREEN;
          active_d       = {PID_W{1'b0}};
          start_game_d   = 1'b0;
          winner_d       = {PID_W{1'b0}};
          winner_valid_d = 1'b0;
          draw_d         = 1'b0;
        end else begin
          state_d = GAME_OVER;
        end
      end
      default: begin
        state_d        = START_SCREEN;
        timer_d        = {TMR_W{1'b0}};
        active_d       = {PID_W{1'b0}};
        start_game_d   = 1'b0;
        winner_d       = {PID_W{1'b0}};
        winner_valid_d = 1'b0;
        draw_d         = 1'b0;
      end
    endcase
    next_turn_d = (state_d == TURN);
    onehot_d    = ((state_d == TURN) || (state_d == ADVANCE)) ? (ONEHOT_BASE << active_d)
                                                              : {N_PLAYERS{1'b0}};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= START_SCREEN;
      timer_q        <= {TMR_W{1'b0}};
      active_q       <= {PID_W{1'b0}};
      onehot_q       <= {N_PLAYERS{1'b0}};
      start_game_q   <= 1'b0;
      next_turn_q    <= 1'b0;
      start_remote_q <= 1'b0;
      timeout_q      <= 1'b0;
      winner_q       <= {PID_W{1'b0}};
      winner_valid_q <= 1'b0;
      draw_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      active_q       <= active_d;
      onehot_q       <= onehot_d;
      start_game_q   <= start_game_d;
      next_turn_q    <= next_turn_d;
      start_remote_q <= start_remote_d;
      timeout_q      <= timeout_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      draw_q         <= draw_d;
    end
  end

  assign turn_onehot   = onehot_q;
  assign active_player = active_q;
  assign state_out     = state_q;
  assign start_game    = start_game_q;
  assign next_turn     = next_turn_q;
  assign start_remote  = start_remote_q;
  assign timeout_pulse = timeout_q;
  assign winner        = winner_q;
  assign winner_valid  = winner_valid_q;
  assign draw          = draw_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: three instances (N=2/T=0, N=4/T=0, N=3/T=8)
// share clock and reset; expected values are hand-computed per step.
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  en2, td2, oh2;
  logic [19:0] hp2;
  logic [0:0]  ap2, w2;
  logic [2:0]  st2;
  logic        sg2, nt2, sr2, to2, wv2, dr2;

  logic [3:0]  en4, td4, oh4;
  logic [39:0] hp4;
  logic [1:0]  ap4, w4;
  logic [2:0]  st4;
  logic        sg4, nt4, sr4, to4, wv4, dr4;

  logic [2:0]  en3, td3, oh3;
  logic [29:0] hp3;
  logic [1:0]  ap3, w3;
  logic [2:0]  st3;
  logic        sg3, nt3, sr3, to3, wv3, dr3;

  turn_sequencer #(.N_PLAYERS(2), .HP_W(10), .TURN_TIMEOUT(0)) u2 (
    .clk(clk), .rst(rst), .enter_pressed(en2), .turn_done(td2), .hp_flat(hp2),
    .turn_onehot(oh2), .active_player(ap2), .state_out(st2), .start_game(sg2),
    .next_turn(nt2), .start_remote(sr2), .timeout_pulse(to2), .winner(w2),
    .winner_valid(wv2), .draw(dr2));

  turn_sequencer #(.N_PLAYERS(4), .HP_W(10), .TURN_TIMEOUT(0)) u4 (
    .clk(clk), .rst(rst), .enter_pressed(en4), .turn_done(td4), .hp_flat(hp4),
    .turn_onehot(oh4), .active_player(ap4), .state_out(st4), .start_game(sg4),
    .next_turn(nt4), .start_remote(sr4), .timeout_pulse(to4), .winner(w4),
    .winner_valid(wv4), .draw(dr4));

  turn_sequencer #(.N_PLAYERS(3), .HP_W(10), .TURN_TIMEOUT(8)) u3 (
    .clk(clk), .rst(rst), .enter_pressed(en3), .turn_done(td3), .hp_flat(hp3),
    .turn_onehot(oh3), .active_player(ap3), .state_out(st3), .start_game(sg3),
    .next_turn(nt3), .start_remote(sr3), .timeout_pulse(to3), .winner(w3),
    .winner_valid(wv3), .draw(dr3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ord4[4];
    int cur;
    ord4 = '{3, 0, 2, 3};
    rst = 1'b0;
    en2 = 2'd0; td2 = 2'd0; hp2 = {10'd100, 10'd100};
    en4 = 4'd0; td4 = 4'd0; hp4 = {10'd100, 10'd100, 10'd0, 10'd100};
    en3 = 3'd0; td3 = 3'd0; hp3 = {10'd100, 10'd100, 10'd100};
    tick();
    chk("rst_state2", 32'(st2), 32'd0);
    chk("rst_onehot4", 32'(oh4), 32'd0);
    chk("rst_start_game3", 32'(sg3), 32'd0);
    chk("rst_active3", 32'(ap3), 32'd0);
    chk("rst_winvalid2", 32'(wv2), 32'd0);
    chk("rst_draw4", 32'(dr4), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_no_enter", 32'(st2), 32'd0);

    // N=2: local start, then turn_done hands over to player 1
    en2 = 2'b01; tick(); en2 = 2'b00;
    chk("a_state_turn", 32'(st2), 32'd1);
    chk("a_onehot", 32'(oh2), 32'd1);
    chk("a_start_game", 32'(sg2), 32'd1);
    chk("a_next_turn", 32'(nt2), 32'd1);
    chk("a_no_remote", 32'(sr2), 32'd0);
    chk("a_active", 32'(ap2), 32'd0);
    td2 = 2'b01; tick(); td2 = 2'b00;
    chk("a_state_adv", 32'(st2), 32'd2);
    chk("a_adv_next_turn", 32'(nt2), 32'd0);
    tick();
    chk("a_state_turn2", 32'(st2), 32'd1);
    chk("a_onehot2", 32'(oh2), 32'd2);
    chk("a_active2", 32'(ap2), 32'd1);

    // N=2: both players die together -> draw
    hp2 = 20'd0; tick();
    chk("d_state_over", 32'(st2), 32'd3);
    chk("d_draw", 32'(dr2), 32'd1);
    chk("d_winvalid", 32'(wv2), 32'd0);
    chk("d_onehot", 32'(oh2), 32'd0);
    chk("d_next_turn", 32'(nt2), 32'd0);

    // N=4: remote start by player 2, player 1 dead and skipped
    en4 = 4'b0100; tick(); en4 = 4'b0000;
    chk("b_remote_pulse", 32'(sr4), 32'd1);
    chk("b_active", 32'(ap4), 32'd2);
    chk("b_onehot", 32'(oh4), 32'd4);
    chk("b_start_game", 32'(sg4), 32'd1);
    td4 = 4'b0001; tick(); td4 = 4'b0000;
    chk("b_remote_once", 32'(sr4), 32'd0);
    chk("b_ignore_other_done", 32'(st4), 32'd1);
    chk("b_still_active", 32'(ap4), 32'd2);
    cur = 2;
    for (int i = 0; i < 4; i++) begin
      td4 = 4'b0001 << cur; tick(); td4 = 4'b0000;
      chk("b_adv", 32'(st4), 32'd2);
      tick();
      chk("b_order", 32'(ap4), 32'(ord4[i]));
      chk("b_order_onehot", 32'(oh4), 32'd1 << ord4[i]);
      cur = ord4[i];
    end

    // N=3, T=8: timeout after 8 TURN cycles, then turn_done beats timeout
    en3 = 3'b001; tick(); en3 = 3'b000;
    chk("c_state_turn", 32'(st3), 32'd1);
    chk("c_active0", 32'(ap3), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("c_no_timeout", 32'(to3), 32'd0);
      chk("c_in_turn", 32'(st3), 32'd1);
    end
    tick();
    chk("c_timeout_adv", 32'(st3), 32'd2);
    chk("c_timeout_pulse", 32'(to3), 32'd1);
    tick();
    chk("c_timeout_once", 32'(to3), 32'd0);
    chk("c_active1", 32'(ap3), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("c_in_turn2", 32'(st3), 32'd1);
    end
    td3 = 3'b010; tick(); td3 = 3'b000;
    chk("c_done_adv", 32'(st3), 32'd2);
    chk("c_done_no_pulse", 32'(to3), 32'd0);
    tick();
    chk("c_active2", 32'(ap3), 32'd2);

    // N=3: only player 1 left alive -> winner 1
    hp3 = {10'd0, 10'd100, 10'd0}; tick();
    chk("w_state_over", 32'(st3), 32'd3);
    chk("w_winner", 32'(w3), 32'd1);
    chk("w_valid", 32'(wv3), 32'd1);
    chk("w_no_draw", 32'(dr3), 32'd0);
    chk("w_onehot", 32'(oh3), 32'd0);
    chk("w_next_turn", 32'(nt3), 32'd0);
    hp3 = {10'd100, 10'd100, 10'd100}; tick();
    chk("w_latched_winner", 32'(w3), 32'd1);
    chk("w_latched_valid", 32'(wv3), 32'd1);
    en3 = 3'b100; tick(); en3 = 3'b000;
    chk("w_back_start", 32'(st3), 32'd0);
    chk("w_start_game_clr", 32'(sg3), 32'd0);
    chk("w_valid_clr", 32'(wv3), 32'd0);

    // Asynchronous reset mid-TURN on the N=4 instance
    chk("r_pre_turn", 32'(st4), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("r_async_state", 32'(st4), 32'd0);
    chk("r_async_onehot", 32'(oh4), 32'd0);
    chk("r_async_active", 32'(ap4), 32'd0);
    chk("r_async_start_game", 32'(sg4), 32'd0);
    chk("r_async_next_turn", 32'(nt4), 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("r_stays_start", 32'(st4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor of the two-player game FSM.
- Sequences turns round-robin among N_PLAYERS players.
- Skips players whose HP is zero, forces a turn end on timeout, and reports a winner or a draw.
- Sits between the input/UART decode (enter and turn-done strobes), the HP trackers, and the render/UART TX logic that consumes turn and state indications.

Parameters:
- N_PLAYERS, 2, number of players (2..8); player 0 is local, the others are remote.
- HP_W, 10, width of each HP value.
- TURN_TIMEOUT, 0, cycles allowed per turn; 0 disables the timeout.
- PID_W, $clog2(N_PLAYERS) (minimum 1), width of player indices (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- enter_pressed  in  N_PLAYERS  per-player enter strobe, 1-cycle pulses.
- turn_done  in  N_PLAYERS  per-player turn-complete strobe.
- hp_flat  in  N_PLAYERS*HP_W  packed HP; player i occupies [i*HP_W +: HP_W].
- turn_onehot  out  N_PLAYERS  one-hot active player; all-zero outside TURN/ADVANCE.
- active_player  out  PID_W  index of the active player.
- state_out  out  3  current state encoding (from the package).
- start_game  out  1  high from game start until GAME_OVER exit.
- next_turn  out  1  high while in TURN.
- start_remote  out  1  1-cycle pulse when a remote player (index ≠ 0) starts the game.
- timeout_pulse  out  1  1-cycle pulse when a turn is forced to end.
- winner  out  PID_W  winning player index; valid while winner_valid is high.
- winner_valid  out  1  high in GAME_OVER when exactly one player is alive.
- draw  out  1  high in GAME_OVER when zero players are alive.

Behaviour:
- Reset (rst low, asynchronous):
  - state = START_SCREEN.
  - All outputs 0; timer 0; active_player 0.
- alive[i] = (hp_i != 0); alive_cnt = popcount(alive).
- START_SCREEN:
  - HP is not checked here.
  - When any enter_pressed bit is high, the lowest set index s becomes the starter.
  - Next cycle: active_player = s, turn_onehot = 1<<s, start_game = 1, state = TURN.
  - start_remote pulses for one cycle if s != 0.
- Global GAME_OVER check, in TURN and ADVANCE only:
  - If alive_cnt <= 1, state = GAME_OVER on the next cycle.
  - This has priority over every other transition.
  - turn_onehot and next_turn are 0 from that cycle onward.
- TURN:
  - next_turn = 1 and the timer increments each cycle.
  - The timer is cleared on TURN entry.
  - Exit to ADVANCE on any of the following:
    - turn_done[active_player] is high;
    - the active player is not alive;
    - the timer equals TURN_TIMEOUT-1 (TURN_TIMEOUT > 0); this exit also pulses timeout_pulse.
  - turn_done from non-active players is ignored.
  - If turn_done and the timeout coincide, turn_done wins and no timeout_pulse is issued.
- ADVANCE (exactly 1 cycle, next_turn = 0):
  - active_player becomes the first alive index after the current one, searching upward with wrap-around modulo N_PLAYERS.
  - The current player itself is the last candidate.
  - Update turn_onehot accordingly; state = TURN.
- GAME_OVER:
  - Exactly one alive player: winner = that index, winner_valid = 1, draw = 0.
  - Zero alive players: draw = 1, winner_valid = 0.
  - Winner and draw are latched on GAME_OVER entry.
  - Any enter_pressed bit returns to START_SCREEN with start_game, winner_valid and draw cleared.
- Unused state encodings go to START_SCREEN with all outputs cleared.
- Timer width is $clog2(TURN_TIMEOUT+1), minimum 1; it must never wrap inside TURN.
- Reset asserted mid-game returns to START_SCREEN immediately, regardless of the current state.

Decomposition:
- Package turn_seq_pkg:
  - state_t enum: START_SCREEN = 0, TURN = 1, ADVANCE = 2, GAME_OVER = 3.
  - Function popcount.
  - Function lowest_set_index.
- Sub-module rr_next_alive:
  - Combinational rotate-priority search.
  - Inputs: alive vector, current index.
  - Outputs: next index, found flag.
  - Parametrised by N_PLAYERS.

Test Plan:
- N=2, T=0: enter_pressed=01, all HP=100 → turn_onehot=01 and start_game=1 one cycle later. turn_done=01 → ADVANCE → turn_onehot=10.
- N=4: start by player 2 → start_remote pulses once. Set hp1=0 with 0 at turn end → order 2,3,0,2,3 (player 1 is skipped).
- N=3, T=8: active player gives no turn_done → timeout_pulse on the 8th TURN cycle, then ADVANCE. turn_done on that same cycle → no pulse.
- N=3: hp0=hp2=0 during TURN → GAME_OVER next cycle, winner=1, winner_valid=1. Then enter_pressed=100 → START_SCREEN with start_game=0.
- N=2: both HP go to 0 in the same cycle → GAME_OVER, draw=1, winner_valid=0.
- Drive rst low asynchronously mid-TURN → all outputs 0 before the next clk edge; state_out=0.
